// File: rtl/vga_pkg.sv
// Shared display geometry and the boss movement state type.
// Constants only; no logic, no latency, no flow control.
// Consumed by the boss movement, draw and hitbox blocks.
package vga_pkg;

    localparam int HOR_PIXELS = 1280;
    localparam int VER_PIXELS = 800;
    localparam int BOSS_LNG   = 128;
    localparam int BOSS_HGT   = 128;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2,
        DASH = 2'd3
    } boss_state_t;

endpackage

// File: rtl/boss_target_sel.sv
// Picks the x position of the highest-aggro player; ties go to the lowest index.
// Purely combinational, zero latency.
// No flow control; the caller decides when to sample tgt_x.
module boss_target_sel #(
    parameter int N_PLAYERS = 2
) (
    input  logic [N_PLAYERS-1:0][11:0] player_x,
    input  logic [N_PLAYERS-1:0][3:0]  player_aggro,
    output logic [11:0]                tgt_x
);

    logic [3:0] best_aggro;

    always_comb begin
        best_aggro = player_aggro[0];
        tgt_x      = player_x[0];
        // Strict compare keeps the earlier player on equal aggro
        for (int i = 1; i < N_PLAYERS; i++) begin
            if (player_aggro[i] > best_aggro) begin
                best_aggro = player_aggro[i];
                tgt_x      = player_x[i];
            end
        end
    end

endmodule

// File: rtl/boss_move_ctrl.sv
// Boss movement FSM: alternates arcing jumps and ground dashes toward the top-aggro player.
// Outputs registered, updated one cycle after each qualifying frame tick.
// No backpressure; ticks with game_active != 1 simply freeze all state.
module boss_move_ctrl
    import vga_pkg::*;
#(
    parameter int N_PLAYERS   = 2,
    parameter int GROUND_Y    = VER_PIXELS - 52 - BOSS_HGT,
    parameter int X_MIN       = BOSS_LNG,
    parameter int X_MAX       = HOR_PIXELS - BOSS_LNG,
    parameter int X_RESET     = HOR_PIXELS / 4,
    parameter int JUMP_HEIGHT = 350,
    parameter int JUMP_SPEED  = 9,
    parameter int FALL_SPEED  = 9,
    parameter int MOVE_STEP   = 5,
    parameter int DASH_STEP   = 12,
    parameter int DASH_EVERY  = 3,
    parameter int WAIT_TICKS  = 30
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_tick,
    input  logic [1:0]                 game_active,
    input  logic [N_PLAYERS-1:0][11:0] player_x,
    input  logic [N_PLAYERS-1:0][3:0]  player_aggro,
    output logic [11:0]                boss_x,
    output logic [11:0]                boss_y,
    output logic                       airborne,
    output logic                       facing,
    output logic                       landed
);

    localparam int WC_W  = $clog2(WAIT_TICKS + 1);
    localparam int ATK_W = $clog2(DASH_EVERY);

    localparam logic signed [12:0] GY_S       = 13'(GROUND_Y);
    localparam logic signed [12:0] RISE_LIM_S = 13'(GROUND_Y - JUMP_HEIGHT + JUMP_SPEED);
    localparam logic signed [12:0] XMIN_S     = 13'(X_MIN);
    localparam logic signed [12:0] XMAX_S     = 13'(X_MAX);
    localparam logic signed [12:0] JUMP_S     = 13'(JUMP_SPEED);
    localparam logic signed [12:0] FALL_S     = 13'(FALL_SPEED);
    localparam logic signed [12:0] MOVE_S     = 13'(MOVE_STEP);
    localparam logic signed [12:0] DASH_S     = 13'(DASH_STEP);

    boss_state_t      state, state_nxt;
    logic [11:0]      boss_x_nxt, boss_y_nxt, dash_tgt, dash_tgt_nxt, tgt_x;
    logic [WC_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic [ATK_W-1:0] atk_cnt, atk_cnt_nxt;
    logic             facing_nxt, landed_nxt, tick;

    logic signed [12:0] x_s, y_s, tgt_s, dt_s;
    logic signed [12:0] air_x, dash_diff, dash_dist, dash_x, tgt_clamp;

    boss_target_sel #(.N_PLAYERS(N_PLAYERS)) u_target_sel (
        .player_x     (player_x),
        .player_aggro (player_aggro),
        .tgt_x        (tgt_x)
    );

    assign tick  = frame_tick && (game_active == 2'd1);
    assign x_s   = signed'({1'b0, boss_x});
    assign y_s   = signed'({1'b0, boss_y});
    assign tgt_s = signed'({1'b0, tgt_x});
    assign dt_s  = signed'({1'b0, dash_tgt});

    // Airborne drift saturates at the arena edges instead of overshooting
    assign air_x = facing ? ((x_s + MOVE_S > XMAX_S) ? XMAX_S : x_s + MOVE_S)
                          : ((x_s - MOVE_S < XMIN_S) ? XMIN_S : x_s - MOVE_S);

    assign dash_diff = dt_s - x_s;
    assign dash_dist = (dash_diff < 0) ? -dash_diff : dash_diff;
    assign dash_x    = (dash_diff < 0) ? x_s - DASH_S : x_s + DASH_S;
    assign tgt_clamp = (tgt_s < XMIN_S) ? XMIN_S : ((tgt_s > XMAX_S) ? XMAX_S : tgt_s);

    assign airborne = (state == RISE) || (state == FALL);

    always_comb begin
        state_nxt    = state;
        boss_x_nxt   = boss_x;
        boss_y_nxt   = boss_y;
        dash_tgt_nxt = dash_tgt;
        wait_cnt_nxt = wait_cnt;
        atk_cnt_nxt  = atk_cnt;
        facing_nxt   = facing;
        landed_nxt   = 1'b0;
        if (tick) begin
            case (state)
                WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt_nxt = wait_cnt - 1'b1;
                    end else begin
                        facing_nxt = (tgt_x < boss_x) ? 1'b0 : 1'b1;
                        if (atk_cnt == ATK_W'(DASH_EVERY - 1)) begin
                            state_nxt    = DASH;
                            atk_cnt_nxt  = '0;
                            dash_tgt_nxt = 12'(tgt_clamp);
                        end else begin
                            state_nxt   = RISE;
                            atk_cnt_nxt = atk_cnt + 1'b1;
                        end
                    end
                end
                RISE: begin
                    boss_x_nxt = 12'(air_x);
                    if (y_s > RISE_LIM_S) boss_y_nxt = 12'(y_s - JUMP_S);
                    else                  state_nxt  = FALL;
                end
                FALL: begin
                    boss_x_nxt = 12'(air_x);
                    if (y_s + FALL_S < GY_S) begin
                        boss_y_nxt = 12'(y_s + FALL_S);
                    end else begin
                        boss_y_nxt   = 12'(GY_S);
                        landed_nxt   = 1'b1;
                        wait_cnt_nxt = WC_W'(WAIT_TICKS);
                        state_nxt    = WAIT;
                    end
                end
                DASH: begin
                    if (dash_dist <= DASH_S) begin
                        boss_x_nxt   = dash_tgt;
                        wait_cnt_nxt = WC_W'(WAIT_TICKS);
                        state_nxt    = WAIT;
                    end else begin
                        boss_x_nxt = 12'(dash_x);
                    end
                end
                default: state_nxt = WAIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WAIT;
            boss_x   <= 12'(X_RESET);
            boss_y   <= 12'(GROUND_Y);
            dash_tgt <= 12'(X_RESET);
            wait_cnt <= '0;
            atk_cnt  <= '0;
            facing   <= 1'b1;
            landed   <= 1'b0;
        end else begin
            state    <= state_nxt;
            boss_x   <= boss_x_nxt;
            boss_y   <= boss_y_nxt;
            dash_tgt <= dash_tgt_nxt;
            wait_cnt <= wait_cnt_nxt;
            atk_cnt  <= atk_cnt_nxt;
            facing   <= facing_nxt;
            landed   <= landed_nxt;
        end
    end

endmodule

// File: tb/tb_boss_move_ctrl.sv
// Bench for boss_move_ctrl: directed attack sequence with literal expectations,
// then randomized ticks/targets/resets checked every cycle against a tick-level model.
module tb_boss_move_ctrl;

    localparam int G   = 620;
    localparam int XR  = 320;
    localparam int XMN = 0;
    localparam int XMX = 1000;
    localparam int JH  = 350;
    localparam int JS  = 9;
    localparam int FS  = 9;
    localparam int MS  = 5;
    localparam int DS  = 12;
    localparam int DE  = 3;
    localparam int WT  = 30;

    localparam int PH_WAIT = 0;
    localparam int PH_RISE = 1;
    localparam int PH_FALL = 2;
    localparam int PH_DASH = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             frame_tick = 1'b0;
    logic [1:0]       game_active = 2'd1;
    logic [1:0][11:0] player_x;
    logic [1:0][3:0]  player_aggro;
    logic [11:0]      boss_x, boss_y;
    logic             airborne, facing, landed;

    int errors = 0;
    int checks = 0;

    int m_phase, m_x, m_y, m_wait, m_atk, m_dt;
    bit m_face, m_land;
    bit rst_seen = 1'b0;

    boss_move_ctrl #(.X_MIN(XMN), .X_MAX(XMX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .game_active  (game_active),
        .player_x     (player_x),
        .player_aggro (player_aggro),
        .boss_x       (boss_x),
        .boss_y       (boss_y),
        .airborne     (airborne),
        .facing       (facing),
        .landed       (landed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int target_x();
        int best = 0;
        for (int i = 1; i < 2; i++)
            if (int'(player_aggro[i]) > int'(player_aggro[best])) best = i;
        return int'(player_x[best]);
    endfunction

    function automatic int drift(input int x, input bit right);
        int n;
        n = right ? x + MS : x - MS;
        if (n > XMX) n = XMX;
        if (n < XMN) n = XMN;
        return n;
    endfunction

    task automatic model_reset();
        m_phase = PH_WAIT; m_x = XR; m_y = G; m_wait = 0; m_atk = 0;
        m_dt = XR; m_face = 1'b1; m_land = 1'b0;
    endtask

    task automatic model_tick();
        int t;
        case (m_phase)
            PH_WAIT: begin
                if (m_wait > 0) m_wait--;
                else begin
                    t = target_x();
                    m_face = (t < m_x) ? 1'b0 : 1'b1;
                    if (m_atk == DE - 1) begin
                        m_phase = PH_DASH;
                        m_atk = 0;
                        m_dt = (t < XMN) ? XMN : ((t > XMX) ? XMX : t);
                    end else begin
                        m_phase = PH_RISE;
                        m_atk++;
                    end
                end
            end
            PH_RISE: begin
                m_x = drift(m_x, m_face);
                if (m_y > G - JH + JS) m_y -= JS;
                else m_phase = PH_FALL;
            end
            PH_FALL: begin
                m_x = drift(m_x, m_face);
                if (m_y + FS < G) m_y += FS;
                else begin
                    m_y = G; m_land = 1'b1; m_wait = WT; m_phase = PH_WAIT;
                end
            end
            default: begin
                if ((m_dt - m_x <= DS) && (m_x - m_dt <= DS)) begin
                    m_x = m_dt; m_wait = WT; m_phase = PH_WAIT;
                end else begin
                    m_x += (m_dt > m_x) ? DS : -DS;
                end
            end
        endcase
    endtask

    always @(negedge rst_n) rst_seen = 1'b1;

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        m_land = 1'b0;
        if (rst_seen || !rst_n) begin
            model_reset();
            rst_seen = 1'b0;
        end
        if (rst_n && frame_tick && game_active == 2'd1) model_tick();
        #1;
        chk("model boss_x", int'(boss_x), m_x);
        chk("model boss_y", int'(boss_y), m_y);
        chk("model airborne", int'(airborne), int'(m_phase == PH_RISE || m_phase == PH_FALL));
        chk("model facing", int'(facing), int'(m_face));
        chk("model landed", int'(landed), int'(m_land));
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk); frame_tick = 1'b1;
            @(negedge clk); frame_tick = 1'b0;
        end
    endtask

    task automatic set_players(input int x0, input int x1, input int a0, input int a1);
        player_x[0] = 12'(x0); player_x[1] = 12'(x1);
        player_aggro[0] = 4'(a0); player_aggro[1] = 4'(a1);
    endtask

    initial begin
        set_players(600, 0, 5, 2);
        repeat (3) @(negedge clk);
        chk("reset boss_x", int'(boss_x), XR);
        chk("reset boss_y", int'(boss_y), G);
        chk("reset facing", int'(facing), 1);
        chk("reset airborne", int'(airborne), 0);
        chk("reset landed", int'(landed), 0);
        rst_n = 1'b1;

        // Attack 1: jump right toward x=600
        tick_n(1);
        chk("launch airborne", int'(airborne), 1);
        chk("launch facing", int'(facing), 1);
        chk("launch no x move", int'(boss_x), XR);
        chk("launch no y move", int'(boss_y), G);
        tick_n(38);
        chk("apex y", int'(boss_y), G - 342);
        tick_n(38);
        chk("pre-land y", int'(boss_y), G - 9);
        chk("pre-land landed", int'(landed), 0);
        tick_n(1);
        chk("land pulse", int'(landed), 1);
        chk("land x", int'(boss_x), 705);
        chk("land y", int'(boss_y), G);
        chk("land airborne", int'(airborne), 0);
        @(negedge clk);
        chk("land pulse single", int'(landed), 0);

        // Attack 2: tie -> player 0 wins; freeze mid-rise; saturate at X_MAX
        tick_n(30);
        chk("wait still ground", int'(airborne), 0);
        set_players(900, 100, 3, 3);
        tick_n(1);
        chk("tie facing", int'(facing), 1);
        tick_n(10);
        game_active = 2'd2;
        tick_n(50);
        chk("freeze x", int'(boss_x), 755);
        chk("freeze y", int'(boss_y), G - 90);
        chk("freeze airborne", int'(airborne), 1);
        game_active = 2'd1;
        tick_n(67);
        chk("sat right x", int'(boss_x), XMX);
        chk("sat right landed", int'(landed), 1);

        // Attack 3: dash to 500
        tick_n(30);
        set_players(500, 100, 5, 2);
        tick_n(1);
        chk("dash facing", int'(facing), 0);
        chk("dash airborne", int'(airborne), 0);
        tick_n(41);
        chk("dash mid x", int'(boss_x), 508);
        tick_n(1);
        chk("dash end x", int'(boss_x), 500);
        chk("dash no landed", int'(landed), 0);
        chk("dash y", int'(boss_y), G);

        // Attacks 4 and 5: jump left, second one saturates at X_MIN
        set_players(0, 100, 5, 2);
        tick_n(31 + 77);
        chk("left jump x", int'(boss_x), 115);
        tick_n(31 + 23);
        chk("reach xmin", int'(boss_x), 0);
        tick_n(10);
        chk("sat left x", int'(boss_x), 0);
        chk("sat left y", int'(boss_y), G - 297);
        tick_n(17);
        chk("mid fall airborne", int'(airborne), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst x", int'(boss_x), XR);
        chk("async rst y", int'(boss_y), G);
        chk("async rst facing", int'(facing), 1);
        chk("async rst airborne", int'(airborne), 0);
        @(negedge clk) rst_n = 1'b1;

        // Randomized phase
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 4999) == 0) ? 1'b0 : 1'b1;
            frame_tick = 1'($urandom_range(0, 1));
            game_active = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
            if ($urandom_range(0, 63) == 0)
                set_players($urandom_range(0, 4095), $urandom_range(0, 1279),
                            $urandom_range(0, 3), $urandom_range(0, 3));
        end
        @(negedge clk);
        rst_n = 1'b1;
        frame_tick = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
